pipelined_unsigned_multiplier: RTL and testbench
================================================

// Module: pipelined_unsigned_multiplier
// PURPOSE
//  Unsigned integer multiplier with compile-time operand widths and pipeline depth.
//  Full-width product; no truncation or rounding.
//  One module covers three arithmetic-kernel configurations:
//    32x32 with 2 stages; 32x48 with 3 stages; 48x48 combinational or 3 stages.
//  Accepts a new operand pair every cycle (fully pipelined, no stalls, no backpressure).
// PARAMETERS
//  A_W      32  width of dataa (1..64)
//  B_W      32  width of datab (1..64)
//  LATENCY  2   clk rising edges from operand sample to product on dataout;
//               legal values 0, 2, 3
//  LIMB_W   16  limb width for partial-product split (DSP-friendly slice)
// PORTS
//  clk      in   1        rising-edge clock; unused when LATENCY=0
//  rst_n    in   1        asynchronous active-low reset; unused when LATENCY=0
//  dataa    in   A_W      unsigned multiplicand
//  datab    in   B_W      unsigned multiplier
//  in_valid in   1        marks dataa/datab as a valid pair; tracked only, never gates data
//  dataout  out  A_W+B_W  unsigned product dataa*datab
//  out_valid out 1        in_valid delayed by LATENCY (equals in_valid when LATENCY=0)
// BEHAVIOUR
//  Reset
//   - rst_n low forces every pipeline register, dataout and out_valid to 0 immediately
//     (asynchronous); no clock needed.
//   - Release is synchronous to the next clk edge.
//   - Reset in mid-stream discards all in-flight products.
//  LATENCY=0
//   - dataout = dataa*datab, purely combinational.
//   - Settles within the same timestep; no registers.
//  LATENCY=2
//   - Edge N: dataa/datab captured into input registers.
//   - Edge N+1: full product of the registered operands captured into the output register.
//   - The pair applied before edge N appears on dataout after edge N+1.
//  LATENCY=3
//   - Edge N: operands registered.
//   - Edge N+1: each operand split into ceil(W/LIMB_W) limbs; every limb cross-product
//     registered.
//   - Edge N+2: shifted partial products summed into the output register.
//   - The pair applied before edge N appears after edge N+2.
//  Throughput and stability
//   - One result per clock; consecutive pairs never interfere.
//   - Constant inputs hold dataout constant indefinitely once the pipeline has filled.
//  Arithmetic
//   - Operands unsigned; product exact over A_W+B_W bits, so it never overflows.
//   - Limb sums use widths of at least A_W+B_W+2 internally, then truncate to A_W+B_W
//     (the truncated bits are always zero).
//  Other
//   - No X propagation from reset values.
//   - Any other LATENCY value is a $error at elaboration.
// TESTING
//  1. A_W=B_W=32, LAT=2: 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001 after exactly 2 edges;
//     dataout at edge 1 is still the previous result.
//  2. A_W=32, B_W=48, LAT=3: 0xFFFFFFFF*0xFFFFFFFFFFFF -> 0xFFFFFFFEFFFF00000001 after 3 edges.
//  3. A_W=B_W=48, LAT=0: 0xFFFFFFFFFFFF squared -> 0xFFFFFFFFFFFE000000000001 combinationally.
//     0*x -> 0; 1*x -> x.
//  4. Streaming: 100 random pairs, one per clock.
//     - Output k matches the reference model at edge k+LATENCY.
//     - After the stream, 4 extra clocks with inputs held: dataout unchanged.
//  5. Reset: assert rst_n=0 between edges with the pipeline full.
//     - dataout and out_valid drop to 0 at once.
//     - After release, the first valid result appears LATENCY edges after the next sampled pair.
//  6. Valid tracking: in_valid pattern 1,0,1,1 -> same pattern on out_valid, delayed by LATENCY.

Source files
------------

// File: rtl/pipelined_unsigned_multiplier.sv
// Unsigned full-width multiplier with selectable pipeline depth.
// LATENCY=0 is purely combinational, LATENCY=2 registers the operands and then
// the product, and LATENCY=3 adds a stage of registered limb cross-products so
// each multiply maps onto a DSP-sized slice before the final summation.
// in_valid rides alongside the data and never gates it.
module pipelined_unsigned_multiplier #(
   parameter int A_W     = 32,
   parameter int B_W     = 32,
   parameter int LATENCY = 2,
   parameter int LIMB_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [A_W-1:0]     dataa,
   input  logic [B_W-1:0]     datab,
   input  logic               in_valid,
   output logic [A_W+B_W-1:0] dataout,
   output logic               out_valid
);

   localparam int P_W = A_W + B_W;

   if (LATENCY == 0) begin : g_lat0

      // Clock and reset have no registers to drive in this configuration.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      // Product settles in the same timestep as the operands.
      always_comb begin
         dataout   = P_W'(dataa) * P_W'(datab);
         out_valid = in_valid;
      end

   end else if (LATENCY == 2) begin : g_lat2

      logic [A_W-1:0] a_q;
      logic [B_W-1:0] b_q;
      logic           v_q;

      // First stage: capture the operand pair and its valid flag.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
         end else begin
            a_q <= dataa;
            b_q <= datab;
            v_q <= in_valid;
         end
      end

      // Second stage: full-width product of the registered operands.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dataout   <= '0;
            out_valid <= 1'b0;
         end else begin
            dataout   <= P_W'(a_q) * P_W'(b_q);
            out_valid <= v_q;
         end
      end

   end else if (LATENCY == 3) begin : g_lat3

      // Operands are zero-padded up to a whole number of limbs.
      localparam int NA    = (A_W + LIMB_W - 1) / LIMB_W;
      localparam int NB    = (B_W + LIMB_W - 1) / LIMB_W;
      localparam int PA_W  = NA * LIMB_W;
      localparam int PB_W  = NB * LIMB_W;
      localparam int PP_W  = 2 * LIMB_W;
      localparam int SUM_W = P_W + 2;

      logic [PA_W-1:0]  a_q;
      logic [PB_W-1:0]  b_q;
      logic             v1_q;
      logic [PP_W-1:0]  pp_q [NA][NB];
      logic             v2_q;
      logic [SUM_W-1:0] sum;
      logic             unused_sum_msbs;

      // The headroom bits of the sum can never be set, so they are dropped.
      assign unused_sum_msbs = ^sum[SUM_W-1:P_W];

      // First stage: capture padded operands and the valid flag.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
         end else begin
            a_q  <= PA_W'(dataa);
            b_q  <= PB_W'(datab);
            v1_q <= in_valid;
         end
      end

      // Second stage: every limb-by-limb cross product gets its own register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < NA; i++) begin
               for (int j = 0; j < NB; j++) begin
                  pp_q[i][j] <= '0;
               end
            end
            v2_q <= 1'b0;
         end else begin
            for (int i = 0; i < NA; i++) begin
               for (int j = 0; j < NB; j++) begin
                  pp_q[i][j] <= PP_W'(a_q[i*LIMB_W +: LIMB_W]) * PP_W'(b_q[j*LIMB_W +: LIMB_W]);
               end
            end
            v2_q <= v1_q;
         end
      end

      // Shift each cross product to its limb weight and accumulate; the sum is
      // exact modulo 2^SUM_W, which already exceeds the largest possible product.
      always_comb begin
         sum = '0;
         for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NB; j++) begin
               sum = sum + (SUM_W'(pp_q[i][j]) << ((i + j) * LIMB_W));
            end
         end
      end

      // Third stage: register the summed product.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dataout   <= '0;
            out_valid <= 1'b0;
         end else begin
            dataout   <= sum[P_W-1:0];
            out_valid <= v2_q;
         end
      end

   end else begin : g_bad

      $error("pipelined_unsigned_multiplier: LATENCY must be 0, 2 or 3");

      logic unused_inputs;
      assign unused_inputs = clk ^ rst_n ^ (^dataa) ^ (^datab);

      // Unsupported depth: drive benign constants so the netlist stays well formed.
      always_comb begin
         dataout   = '0;
         out_valid = in_valid;
      end

   end

endmodule

// File: tb/tb_pipelined_unsigned_multiplier.sv
// Self-checking bench for pipelined_unsigned_multiplier.
// Four instances share one stimulus stream: 32x32/L2, 32x48/L3, 48x48/L0 and
// 48x48/L3. Hand-computed vectors cover the corner products; a delay-line
// reference covers streaming, valid tracking and mid-stream reset.
module tb_pipelined_unsigned_multiplier;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [47:0] a_in = '0;
   logic [47:0] b_in = '0;
   logic        in_valid = 1'b0;

   logic [63:0] dout_a;
   logic [79:0] dout_b;
   logic [95:0] dout_c;
   logic [95:0] dout_d;
   logic        vld_a, vld_b, vld_c, vld_d;

   int checks = 0;
   int failures = 0;

   // Reference delay line: index 0 holds the pair sampled at the latest edge.
   logic [47:0] m_a [0:2];
   logic [47:0] m_b [0:2];
   logic        m_v [0:2];

   localparam logic [47:0] ONES48 = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] B_PAT  = 48'h1234_5678_9ABC;

   pipelined_unsigned_multiplier #(.A_W(32), .B_W(32), .LATENCY(2), .LIMB_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .dataa(a_in[31:0]), .datab(b_in[31:0]),
      .in_valid(in_valid), .dataout(dout_a), .out_valid(vld_a));

   pipelined_unsigned_multiplier #(.A_W(32), .B_W(48), .LATENCY(3), .LIMB_W(16)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .dataa(a_in[31:0]), .datab(b_in),
      .in_valid(in_valid), .dataout(dout_b), .out_valid(vld_b));

   pipelined_unsigned_multiplier #(.A_W(48), .B_W(48), .LATENCY(0), .LIMB_W(16)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .dataa(a_in), .datab(b_in),
      .in_valid(in_valid), .dataout(dout_c), .out_valid(vld_c));

   pipelined_unsigned_multiplier #(.A_W(48), .B_W(48), .LATENCY(3), .LIMB_W(16)) u_dut_d (
      .clk(clk), .rst_n(rst_n), .dataa(a_in), .datab(b_in),
      .in_valid(in_valid), .dataout(dout_d), .out_valid(vld_d));

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_a[i] <= '0;
            m_b[i] <= '0;
            m_v[i] <= 1'b0;
         end
      end else begin
         m_a[0] <= a_in;     m_b[0] <= b_in;     m_v[0] <= in_valid;
         m_a[1] <= m_a[0];   m_b[1] <= m_b[0];   m_v[1] <= m_v[0];
         m_a[2] <= m_a[1];   m_b[2] <= m_b[1];   m_v[2] <= m_v[1];
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [95:0] ref_prod(input logic [47:0] a, input logic [47:0] b,
                                            input int aw, input int bw);
      logic [47:0] am, bm;
      am = a & ((48'd1 << aw) - 48'd1);
      bm = b & ((48'd1 << bw) - 48'd1);
      return {48'd0, am} * {48'd0, bm};
   endfunction

   task automatic check_output(input string tag, input logic [95:0] observed,
                               input logic [95:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [47:0] a, input logic [47:0] b, input logic v);
      a_in     = a;
      b_in     = b;
      in_valid = v;
   endtask

   task automatic check_pipes();
      check_output("a_prod", 96'(dout_a), ref_prod(m_a[1], m_b[1], 32, 32));
      check_output("a_vld",  96'(vld_a),  96'(m_v[1]));
      check_output("b_prod", 96'(dout_b), ref_prod(m_a[2], m_b[2], 32, 48));
      check_output("b_vld",  96'(vld_b),  96'(m_v[2]));
      check_output("c_prod", dout_c,      ref_prod(a_in, b_in, 48, 48));
      check_output("c_vld",  96'(vld_c),  96'(in_valid));
      check_output("d_prod", dout_d,      ref_prod(m_a[2], m_b[2], 48, 48));
      check_output("d_vld",  96'(vld_d),  96'(m_v[2]));
   endtask

   task automatic random_pair(output logic [47:0] a, output logic [47:0] b);
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      a = r[47:0];
      r = {$urandom(), $urandom()};
      b = r[47:0];
   endtask

   initial begin
      logic [47:0] ra, rb;
      logic        vpat [0:7];
      vpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      // Power-on reset before any clock edge
      #1 rst_n = 1'b0;
      #2;
      check_output("rst_a_prod", 96'(dout_a), 96'd0);
      check_output("rst_b_prod", 96'(dout_b), 96'd0);
      check_output("rst_d_prod", dout_d, 96'd0);
      check_output("rst_a_vld", 96'(vld_a), 96'd0);
      check_output("rst_d_vld", 96'(vld_d), 96'd0);
      check_output("rst_c_prod", dout_c, 96'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus('0, '0, 1'b0);
      repeat (3) @(negedge clk);

      // Directed corner products
      apply_stimulus(ONES48, ONES48, 1'b1);
      #1 check_output("c_ones_sq", dout_c, 96'hFFFF_FFFF_FFFE_0000_0000_0001);
      @(negedge clk);
      check_output("a_edge1_prev", 96'(dout_a), 96'd0);
      apply_stimulus(48'd0, B_PAT, 1'b0);
      #1 check_output("c_zero_x", dout_c, 96'd0);
      @(negedge clk);
      check_output("a_ones_sq", 96'(dout_a), 96'hFFFF_FFFE_0000_0001);
      check_output("a_ones_vld", 96'(vld_a), 96'd1);
      check_output("b_edge2_prev", 96'(dout_b), 96'd0);
      apply_stimulus(48'd1, B_PAT, 1'b0);
      #1 check_output("c_one_x", dout_c, 96'h1234_5678_9ABC);
      @(negedge clk);
      check_output("b_ones_prod", 96'(dout_b), 96'hFFFF_FFFE_FFFF_0000_0001);
      check_output("d_ones_sq", dout_d, 96'hFFFF_FFFF_FFFE_0000_0000_0001);
      check_output("a_zero_x", 96'(dout_a), 96'd0);
      @(negedge clk);
      check_output("a_one_x", 96'(dout_a), 96'h5678_9ABC);
      check_output("b_zero_x", 96'(dout_b), 96'd0);
      check_output("d_zero_x", dout_d, 96'd0);
      @(negedge clk);
      check_output("b_one_x", 96'(dout_b), 96'h1234_5678_9ABC);
      check_output("d_one_x", dout_d, 96'h1234_5678_9ABC);
      apply_stimulus('0, '0, 1'b0);
      repeat (4) @(negedge clk);

      // Valid tracking with pattern 1,0,1,1 followed by idle cycles
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(48'h0000_0001_0003 + 48'(i), 48'h0000_0002_0005 + 48'(i), vpat[i]);
         @(negedge clk);
         check_pipes();
      end

      // Streaming: one random pair per clock, then hold the last pair
      for (int k = 0; k < 100; k++) begin
         random_pair(ra, rb);
         apply_stimulus(ra, rb, 1'b1);
         @(negedge clk);
         check_pipes();
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_pipes();
      end

      // Mid-stream reset with the pipeline full
      for (int k = 0; k < 5; k++) begin
         random_pair(ra, rb);
         apply_stimulus(ra, rb, 1'b1);
         @(negedge clk);
         check_pipes();
      end
      #2 rst_n = 1'b0;
      #1;
      check_output("mid_rst_a_prod", 96'(dout_a), 96'd0);
      check_output("mid_rst_a_vld", 96'(vld_a), 96'd0);
      check_output("mid_rst_b_prod", 96'(dout_b), 96'd0);
      check_output("mid_rst_b_vld", 96'(vld_b), 96'd0);
      check_output("mid_rst_d_prod", dout_d, 96'd0);
      check_output("mid_rst_d_vld", 96'(vld_d), 96'd0);
      @(negedge clk);
      check_pipes();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         random_pair(ra, rb);
         apply_stimulus(ra, rb, 1'b1);
         @(negedge clk);
         check_pipes();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
